// File: rtl/common.sv
// Shared scalar types used across the pipeline.
package common;

  typedef logic [63:0] u64;

endpackage

// File: rtl/pipes.sv
// Pipeline payload types passed between fetch, decode and later stages.
package pipes;

  import common::*;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } control_t;

  typedef struct packed {
    u64          pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;

  typedef struct packed {
    u64          pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  dst;
    u64          srca;
    u64          srcb;
    u64          imm_64;
    logic        valid;
  } decode_data_t;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int dq_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decode_queue_stage_checker.sv
// Runtime invariants of the decode queue stage.
module decode_queue_stage_checker #(
  parameter int unsigned DEPTH = 4
) (
  input logic                       clk,
  input logic                       reset,
  input logic                       flush,
  input logic                       push,
  input logic                       full,
  input logic                       data_d_valid,
  input logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && full));

  a_count_in_range: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH));

  a_flush_empties: assert property (@(posedge clk) disable iff (!reset)
    flush |=> (count == CW'(0)) && !data_d_valid);

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous circular-buffer FIFO of fetch_data_t entries with wrap-bit pointers.
module fetch_fifo
  import pipes::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_data_t                  wdata,
  output fetch_data_t                  head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = dq_ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_data_t   mem_r [DEPTH];
  logic [PW-1:0] head_ptr_r;
  logic [PW-1:0] tail_ptr_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (head_ptr_r == tail_ptr_r);
  assign full      = (head_ptr_r[AW-1:0] == tail_ptr_r[AW-1:0]) &&
                     (head_ptr_r[AW] != tail_ptr_r[AW]);
  assign count     = CW'(tail_ptr_r - head_ptr_r);
  assign push_ok_s = push && !full && !clear;
  assign pop_ok_s  = pop && !empty && !clear;
  assign head      = mem_r[head_ptr_r[AW-1:0]];

  // Pointer advance; reset and clear both empty the buffer.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      head_ptr_r <= '0;
      tail_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        tail_ptr_r <= tail_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        head_ptr_r <= head_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_r[tail_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// DEPTH-entry instruction queue between fetch and decode with optional bypass
// and a registered decode output.
module decode_queue_stage
  import common::*;
  import pipes::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  fetch_data_t                dataF,
  output logic                       in_ready,
  output logic [31:0]                head_instr,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  input  u64                         rd1,
  input  u64                         rd2,
  input  control_t                   ctl,
  input  u64                         imm_64,
  input  logic                       stall,
  input  logic                       flush,
  output decode_data_t               dataD,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  fetch_data_t  q_head_s;
  fetch_data_t  head_s;
  logic         q_full_s;
  logic         q_empty_s;
  logic         adv_s;
  logic         bypass_take_s;
  logic         push_s;
  logic         pop_s;
  decode_data_t dataD_r;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (dataF),
    .head  (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (count)
  );

  // Head selection: queued entry first, then same-cycle bypass of fetch data.
  always_comb begin
    head_s = '0;
    if (!q_empty_s) begin
      head_s = q_head_s;
    end else if (BYPASS && dataF.valid) begin
      head_s = dataF;
    end else begin
      head_s = '0;
    end
  end

  // in_ready looks only at registered occupancy, never at stall or dequeue.
  assign in_ready      = !q_full_s;
  assign adv_s         = head_s.valid && !stall && !flush;
  assign bypass_take_s = BYPASS && q_empty_s && dataF.valid && adv_s;
  assign push_s        = dataF.valid && in_ready && !flush && !bypass_take_s;
  assign pop_s         = adv_s && !q_empty_s;

  assign head_instr = head_s.raw_instr;
  assign rs1        = head_s.raw_instr[19:15];
  assign rs2        = head_s.raw_instr[24:20];
  assign dataD      = dataD_r;

  // Decode output register: reset > flush > stall > advance > bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dataD_r <= '0;
    end else if (flush) begin
      dataD_r.valid <= 1'b0;
    end else if (stall) begin
      dataD_r <= dataD_r;
    end else if (adv_s) begin
      dataD_r.pc        <= head_s.pc;
      dataD_r.raw_instr <= head_s.raw_instr;
      dataD_r.ctl       <= ctl;
      dataD_r.dst       <= head_s.raw_instr[11:7];
      dataD_r.srca      <= rd1;
      dataD_r.srcb      <= rd2;
      dataD_r.imm_64    <= imm_64;
      dataD_r.valid     <= 1'b1;
    end else begin
      dataD_r.valid <= 1'b0;
    end
  end

  decode_queue_stage_checker #(
    .DEPTH (DEPTH)
  ) u_checker (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .push         (push_s),
    .full         (q_full_s),
    .data_d_valid (dataD_r.valid),
    .count        (count)
  );

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: one bypassing and one non-bypassing instance.
module tb_decode_queue_stage;

  import common::*;
  import pipes::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic         clk = 1'b0;
  logic         reset;
  fetch_data_t  data_f;
  logic         stall;
  logic         flush;

  logic         in_ready_a, in_ready_b;
  logic [31:0]  head_instr_a, head_instr_b;
  logic [4:0]   rs1_a, rs2_a, rs1_b, rs2_b;
  u64           rd1_a, rd2_a, rd1_b, rd2_b, imm_a, imm_b;
  control_t     ctl_a, ctl_b;
  decode_data_t data_d_a, data_d_b;
  logic [CW-1:0] count_a, count_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  function automatic control_t dec_ctl(input logic [31:0] ins);
    control_t c;
    c           = '0;
    c.alu_op    = {1'b0, ins[14:12]};
    c.alu_src   = (ins[6:0] == 7'h13);
    c.reg_write = 1'b1;
    return c;
  endfunction

  function automatic u64 dec_imm(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:20]};
  endfunction

  function automatic fetch_data_t mk(input int id);
    fetch_data_t f;
    f.pc        = 64'h8000_0000 + 64'(id) * 64'd4;
    f.raw_instr = {12'(id), 5'(id), 3'b000, 5'(id + 1), 7'h13};
    f.valid     = 1'b1;
    return f;
  endfunction

  // Register-file and decoder models driven from each instance's head.
  assign rd1_a = 64'(rs1_a) + 64'd1;
  assign rd2_a = 64'(rs2_a) + 64'd1000;
  assign ctl_a = dec_ctl(head_instr_a);
  assign imm_a = dec_imm(head_instr_a);
  assign rd1_b = 64'(rs1_b) + 64'd1;
  assign rd2_b = 64'(rs2_b) + 64'd1000;
  assign ctl_b = dec_ctl(head_instr_b);
  assign imm_b = dec_imm(head_instr_b);

  decode_queue_stage #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .dataF(data_f), .in_ready(in_ready_a),
    .head_instr(head_instr_a), .rs1(rs1_a), .rs2(rs2_a), .rd1(rd1_a), .rd2(rd2_a),
    .ctl(ctl_a), .imm_64(imm_a), .stall(stall), .flush(flush),
    .dataD(data_d_a), .count(count_a)
  );

  decode_queue_stage #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .dataF(data_f), .in_ready(in_ready_b),
    .head_instr(head_instr_b), .rs1(rs1_b), .rs2(rs2_b), .rd1(rd1_b), .rd2(rd2_b),
    .ctl(ctl_b), .imm_64(imm_b), .stall(stall), .flush(flush),
    .dataD(data_d_b), .count(count_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    logic stall_prev;

    reset  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    data_f = '0;
    tick;
    tick;
    chk("rst_valid", 64'(data_d_a.valid), 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    reset = 1'b1;

    // Bypass of addi x5,x6,10 straight into dataD.
    data_f.pc        = 64'h8000_0000;
    data_f.raw_instr = 32'h00A3_0293;
    data_f.valid     = 1'b1;
    #1;
    chk("byp_rs1", 64'(rs1_a), 64'd6);
    tick;
    data_f = '0;
    chk("byp_valid", 64'(data_d_a.valid), 64'd1);
    chk("byp_pc", data_d_a.pc, 64'h8000_0000);
    chk("byp_dst", 64'(data_d_a.dst), 64'd5);
    chk("byp_srca", data_d_a.srca, 64'd7);
    chk("byp_srcb", data_d_a.srcb, 64'd1010);
    chk("byp_imm", data_d_a.imm_64, 64'd10);
    chk("byp_alu_src", 64'(data_d_a.ctl.alu_src), 64'd1);
    chk("byp_count", 64'(count_a), 64'd0);

    // Fill under stall: four accepted, fifth refused, dataD frozen.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_f = mk(k);
      #1;
      chk($sformatf("fill_in_ready_%0d", k), 64'(in_ready_a), (k < 4) ? 64'd1 : 64'd0);
      tick;
      chk($sformatf("fill_hold_raw_%0d", k), 64'(data_d_a.raw_instr), 64'h00A3_0293);
      chk($sformatf("fill_hold_valid_%0d", k), 64'(data_d_a.valid), 64'd1);
    end
    chk("fill_count", 64'(count_a), 64'd4);
    chk("fill_in_ready", 64'(in_ready_a), 64'd0);

    // Drain in FIFO order.
    data_f = '0;
    stall  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick;
      chk($sformatf("drain_pc_%0d", j), data_d_a.pc, 64'h8000_0000 + 64'(j) * 64'd4);
      chk($sformatf("drain_dst_%0d", j), 64'(data_d_a.dst), 64'(j + 1));
      chk($sformatf("drain_srca_%0d", j), data_d_a.srca, 64'(j + 1));
      chk($sformatf("drain_count_%0d", j), 64'(count_a), 64'(3 - j));
    end
    tick;
    chk("drain_bubble", 64'(data_d_a.valid), 64'd0);

    // Wrap-around stream with periodic stall.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      stall = (c % 3 == 2);
      #1;
      if (sent < 10 && in_ready_a) begin
        data_f = mk(10 + sent);
        sent++;
      end else begin
        data_f = '0;
      end
      stall_prev = stall;
      tick;
      if (!stall_prev && data_d_a.valid) begin
        chk($sformatf("wrap_pc_%0d", got), data_d_a.pc, mk(10 + got).pc);
        got++;
      end
    end
    data_f = '0;
    stall  = 1'b0;
    chk("wrap_all", 64'(got), 64'd10);
    chk("wrap_count", 64'(count_a), 64'd0);

    // Flush with three queued and a valid fetch in the same cycle.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_f = mk(20 + k);
      tick;
    end
    chk("flush_pre_count", 64'(count_a), 64'd3);
    flush  = 1'b1;
    data_f = mk(23);
    tick;
    flush = 1'b0;
    chk("flush_count", 64'(count_a), 64'd0);
    chk("flush_valid", 64'(data_d_a.valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready_a), 64'd1);
    stall  = 1'b0;
    data_f = mk(24);
    tick;
    data_f = '0;
    chk("flush_next_valid", 64'(data_d_a.valid), 64'd1);
    chk("flush_next_pc", data_d_a.pc, mk(24).pc);

    // Reset mid-stream.
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_f = mk(30 + k);
      tick;
    end
    chk("mrst_pre_count", 64'(count_a), 64'd2);
    reset  = 1'b0;
    data_f = '0;
    tick;
    chk("mrst_all_zero", 64'(data_d_a == '0), 64'd1);
    chk("mrst_pc", data_d_a.pc, 64'd0);
    chk("mrst_srca", data_d_a.srca, 64'd0);
    chk("mrst_count", 64'(count_a), 64'd0);
    chk("mrst_in_ready", 64'(in_ready_a), 64'd1);
    chk("mrst_nb_count", 64'(count_b), 64'd0);
    chk("mrst_nb_valid", 64'(data_d_b.valid), 64'd0);
    reset  = 1'b1;
    stall  = 1'b0;
    data_f = mk(40);
    tick;
    data_f = '0;
    chk("lat_byp_valid", 64'(data_d_a.valid), 64'd1);
    chk("lat_byp_pc", data_d_a.pc, mk(40).pc);
    chk("lat_nb_valid1", 64'(data_d_b.valid), 64'd0);
    chk("lat_nb_count1", 64'(count_b), 64'd1);
    tick;
    chk("lat_nb_valid2", 64'(data_d_b.valid), 64'd1);
    chk("lat_nb_pc", data_d_b.pc, mk(40).pc);
    chk("lat_nb_count2", 64'(count_b), 64'd0);
    chk("lat_byp_bubble", 64'(data_d_a.valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Parametrised successor to the single-entry decode stage: a DEPTH-entry instruction queue between fetch and decode, feeding a registered decode output.
- The queue head drives register-file read addresses and the external decoder. Head fields plus rd1/rd2/ctl/imm are captured into dataD on advance.
- Adds stall back-pressure, flush, an optional same-cycle bypass, and an occupancy count. The single-entry stage has none of these.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- BYPASS, 1, 1 = an empty queue lets incoming fetch data go straight to decode; 0 = every instruction passes through the queue.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising edge with reset==0.
- dataF  in  fetch_data_t  fetched instruction; dataF.valid qualifies it.
- in_ready  out  1  queue can accept dataF this cycle.
- head_instr  out  32  raw instruction at the head, driven to the external decoder.
- rs1  out  5  head_instr[19:15], register-file read address 1.
- rs2  out  5  head_instr[24:20], register-file read address 2.
- rd1  in  u64  register-file data for rs1, same cycle.
- rd2  in  u64  register-file data for rs2, same cycle.
- ctl  in  control_t  decoder output for head_instr, same cycle.
- imm_64  in  u64  decoder immediate for head_instr, same cycle.
- stall  in  1  downstream not accepting; dataD must hold.
- flush  in  1  discard all queued and in-flight instructions.
- dataD  out  decode_data_t  registered decode output; dataD.valid qualifies it.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Storage: circular buffer of fetch_data_t entries.
  - head and tail pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty: pointers equal. full: low bits equal, MSBs differ.
  - count = tail - head.
- in_ready = !full, combinational from registered state. It does not depend on the same-cycle dequeue, so a full queue never enqueues, even while dequeuing.
- Head selection:
  - queue non-empty: head = entry[head_ptr], head_valid = 1.
  - queue empty, BYPASS==1 and dataF.valid: head = dataF, head_valid = 1.
  - otherwise head_valid = 0 and head_instr = 0.
- adv = head_valid && !stall && !flush.
- Enqueue:
  - occurs when dataF.valid && in_ready && !flush, except when the bypass path consumed dataF on adv.
  - writes entry[tail] and increments tail.
- Dequeue: when adv and the queue is non-empty, head increments.
- dataD update, highest priority first:
  - reset (reset==0): all dataD fields 0, pointers 0.
  - flush: dataD.valid <= 0, pointers cleared, dataF dropped; other dataD fields don't-care.
  - stall: dataD holds every field.
  - adv: dataD <= {pc, raw_instr from head; ctl; dst = raw_instr[11:7]; srca = rd1; srcb = rd2; imm_64; valid = 1}.
  - otherwise (no stall, no head): dataD.valid <= 0, a bubble.
- Latency from dataF valid to dataD valid:
  - 1 cycle via bypass.
  - 2 cycles when the instruction is enqueued and the queue was empty.
  - Additional cycles per older entry.
- Ordering: strictly FIFO. Wrap-around of the pointers is transparent to ordering.
- Simultaneous events:
  - enqueue + dequeue in the same cycle: count unchanged.
  - flush + stall: flush wins.
  - flush + dataF.valid: dataF is lost; fetch redirection is external.
- Reset mid-operation: same as flush, plus all dataD fields zeroed. in_ready = 1 in the first cycle after reset.
- No combinational path from stall to in_ready.

Decomposition:
- pipes package holds fetch_data_t, decode_data_t and control_t (existing), plus a new function dq_ptr_width(DEPTH) returning $clog2(DEPTH)+1.
- common package holds u64 (existing).
- One natural sub-module: fetch_fifo.
  - Generic synchronous FIFO of fetch_data_t with DEPTH.
  - Ports: push, pop, full, empty, count, head data.
  - decode_queue_stage wraps it with the bypass, capture and flush logic.

Test Plan:
1. Bypass, BYPASS=1: queue empty, dataF valid with pc=0x80000000, raw=0x00A30293 (addi x5,x6,10), rd1=7, imm_64=10, no stall -> next cycle dataD.valid=1, dst=5, srca=7, imm_64=10; count stays 0.
2. Fill with stall: DEPTH=4, stall=1, valid fetch for 5 cycles -> count reaches 4, in_ready=0 on cycle 5, fifth instruction not accepted, dataD frozen throughout.
3. Drain order: release stall from the full state -> dataD.pc sequence 0x80000000, …04, …08, …0C on consecutive cycles; count decrements 4→0.
4. Wrap-around: stream 10 instructions with stall toggled every 3rd cycle -> all 10 pcs emerge in order, no duplicates or drops.
5. Flush: count=3, assert flush together with a valid dataF -> next cycle count=0, dataD.valid=0, in_ready=1; the subsequent instruction emerges next.
6. Reset mid-stream: count=2, reset=0 for one cycle -> dataD entirely zero, count=0; with BYPASS=0 the first instruction after reset takes 2 cycles.
